shift_reg_univ: RTL and testbench

Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit universal register with hold, shift-left, shift-right and parallel-load modes. It adds a clock enable, serial in/out at both ends, and a shift counter with a DONE flag marking a full word shifted since the last load. It is used as the serialiser/deserialiser building block in later tasks, with the same single-clock, write-on-falling / sample-on-rising test discipline.

---
 rtl/shift_reg_univ.sv | 117 +++++++++++
 tb/tb_shift_reg_univ.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// shift_reg_univ
// WIDTH-bit universal shift register: hold, shift left, shift right and
// parallel load, with clock enable, serial in/out at both ends and a
// saturating shift counter whose DONE flag marks a full word shifted since
// the last load or reset.
//
// Optional build macro: SHIFT_REG_UNIV_ROTATE_EN
//   defined   - ROT=1 during a shift recirculates the bit shifted out
//   undefined - ROT is ignored; shifts always take SIN_R / SIN_L
//
// Ports
//   CLK     clock, all state changes on the rising edge
//   RST     synchronous active-high reset (wins over EN and MODE)
//   EN      clock enable; 0 holds Q and CNT
//   MODE    00 hold, 01 shift left, 10 shift right, 11 parallel load
//   D       parallel load data
//   SIN_R   serial input entering bit 0 on a left shift
//   SIN_L   serial input entering bit WIDTH-1 on a right shift
//   ROT     rotate request (optional feature only)
//   Q       register contents
//   SOUT_L  Q[WIDTH-1]
//   SOUT_R  Q[0]
//   CNT     shifts since last load/reset, saturates at WIDTH
//   DONE    CNT == WIDTH
module shift_reg_univ #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic [1:0]                   MODE,
    input  logic [WIDTH-1:0]             D,
    input  logic                         SIN_R,
    input  logic                         SIN_L,
    input  logic                         ROT,
    output logic [WIDTH-1:0]             Q,
    output logic                         SOUT_L,
    output logic                         SOUT_R,
    output logic [$clog2(WIDTH+1)-1:0]   CNT,
    output logic                         DONE
);

    localparam int                CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     CNT_MAX = CW'(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHL   = 2'b01;
    localparam logic [1:0] MODE_SHR   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_inc;
    logic             fill_l;   // bit entering at position 0 on a left shift
    logic             fill_r;   // bit entering at position WIDTH-1 on a right shift

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    always_comb begin
        fill_l = SIN_R;
        fill_r = SIN_L;
        if (ROT) begin
            fill_l = q_reg[WIDTH-1];
            fill_r = q_reg[0];
        end
    end
`else
    // ROT exists on the port list in every build but only the rotate build uses it.
    logic unused_rot;
    assign unused_rot = ROT;

    always_comb begin
        fill_l = SIN_R;
        fill_r = SIN_L;
    end
`endif

    // Counter saturates so DONE stays asserted once a full word has gone by.
    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_reg   <= RESET_VAL;
            cnt_reg <= '0;
        end else if (EN) begin
            case (MODE)
                MODE_SHL: begin
                    q_reg   <= {q_reg[WIDTH-2:0], fill_l};
                    cnt_reg <= cnt_inc;
                end
                MODE_SHR: begin
                    q_reg   <= {fill_r, q_reg[WIDTH-1:1]};
                    cnt_reg <= cnt_inc;
                end
                MODE_LOAD: begin
                    q_reg   <= D;
                    cnt_reg <= '0;
                end
                MODE_HOLD: begin
                    q_reg   <= q_reg;
                    cnt_reg <= cnt_reg;
                end
                default: begin
                    q_reg   <= q_reg;
                    cnt_reg <= cnt_reg;
                end
            endcase
        end
    end

    assign Q      = q_reg;
    assign CNT    = cnt_reg;
    assign SOUT_L = q_reg[WIDTH-1];
    assign SOUT_R = q_reg[0];
    assign DONE   = (cnt_reg == CNT_MAX);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Testbench for shift_reg_univ (WIDTH=8, RESET_VAL=8'hA5).
// Directed vector table, hand-written serialise and rotate sequences, then
// random traffic checked against an arithmetic reference model.
module tb_shift_reg_univ;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [7:0] D = 8'h00;
    logic       SIN_R = 1'b0;
    logic       SIN_L = 1'b0;
    logic       ROT = 1'b0;
    logic [7:0] Q;
    logic       SOUT_L, SOUT_R;
    logic [3:0] CNT;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_q   = 0;
    int m_cnt = 0;

    shift_reg_univ #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .D(D),
        .SIN_R(SIN_R), .SIN_L(SIN_L), .ROT(ROT),
        .Q(Q), .SOUT_L(SOUT_L), .SOUT_R(SOUT_R), .CNT(CNT), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sinr;
        logic       sinl;
        int         exp_q;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic en, logic [1:0] mode, logic [7:0] d,
                                logic sinr, logic sinl, int eq, int ec);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.d = d;
        v.sinr = sinr; v.sinl = sinl; v.exp_q = eq; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic model_step();
        int rot_on;
        int inb;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        rot_on = int'(ROT);
`else
        rot_on = 0;
`endif
        if (RST) begin
            m_q = int'(RV);
            m_cnt = 0;
        end else if (EN) begin
            case (MODE)
                2'b01: begin
                    inb = rot_on ? (m_q / 128) : int'(SIN_R);
                    m_q = (m_q * 2) % 256 + inb;
                    m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
                end
                2'b10: begin
                    inb = rot_on ? (m_q % 2) : int'(SIN_L);
                    m_q = m_q / 2 + inb * 128;
                    m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
                end
                2'b11: begin
                    m_q = int'(D);
                    m_cnt = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(string name, int eq, int ec);
        int edone, esl, esr;
        edone = (ec == W) ? 1 : 0;
        esl = eq / 128;
        esr = eq % 2;
        checks++;
        if (int'(Q) != eq || int'(CNT) != ec || int'(DONE) != edone ||
            int'(SOUT_L) != esl || int'(SOUT_R) != esr) begin
            errors++;
            $display("FAIL %s: got Q=%02h CNT=%0d DONE=%0d SOUT_L=%0d SOUT_R=%0d, want Q=%02h CNT=%0d DONE=%0d SOUT_L=%0d SOUT_R=%0d",
                     name, Q, CNT, DONE, SOUT_L, SOUT_R, eq, ec, edone, esl, esr);
        end
    endtask

    // Drive on the falling edge, let the rising edge act, sample 1 time unit later.
    task automatic cyc(logic rst, logic en, logic [1:0] mode, logic [7:0] d,
                       logic sinr, logic sinl, logic rot);
        @(negedge CLK);
        RST = rst; EN = en; MODE = mode; D = d;
        SIN_R = sinr; SIN_L = sinl; ROT = rot;
        @(posedge CLK);
        model_step();
        #1;
    endtask

    initial begin
        logic [7:0] ser_exp;
        int exp_rot1, exp_rot3;

        // reset / reset-wins
        vecs.push_back(mk(1, 0, 2'b00, 8'h00, 0, 0, 'hA5, 0));
        vecs.push_back(mk(1, 1, 2'b11, 8'hFF, 0, 0, 'hA5, 0));
        // load then hold, EN=0 blocks load
        vecs.push_back(mk(0, 1, 2'b11, 8'h3C, 0, 0, 'h3C, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 2'b00, 8'hFF, 1, 1, 'h3C, 0));
        vecs.push_back(mk(0, 0, 2'b11, 8'h00, 1, 1, 'h3C, 0));
        // deserialise from zero, SIN_L held high to show it is ignored
        vecs.push_back(mk(0, 1, 2'b11, 8'h00, 0, 0, 'h00, 0));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 1, 1, 'h01, 1));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 0, 1, 'h02, 2));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 1, 1, 'h05, 3));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 1, 1, 'h0B, 4));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 0, 1, 'h16, 5));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 0, 1, 'h2C, 6));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 1, 1, 'h59, 7));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 0, 1, 'hB2, 8));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 0, 1, 'h64, 8));   // saturation
        // reset mid-operation
        vecs.push_back(mk(0, 1, 2'b11, 8'hF0, 0, 0, 'hF0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 1, 0, 'hE1, 1));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 1, 0, 'hC3, 2));
        vecs.push_back(mk(0, 1, 2'b01, 8'h00, 1, 0, 'h87, 3));
        vecs.push_back(mk(1, 1, 2'b01, 8'h00, 1, 0, 'hA5, 0));

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sinr, vecs[i].sinl, 1'b0);
            check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt);
        end

        // serialise 8'h96 LSB first through SOUT_R
        ser_exp = 8'h96;
        cyc(0, 1, 2'b11, 8'h96, 0, 0, 0);
        check_all("ser_load", 'h96, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (SOUT_R !== ser_exp[i]) begin
                errors++;
                $display("FAIL ser_bit%0d: got SOUT_R=%0d want %0d", i, SOUT_R, ser_exp[i]);
            end
            cyc(0, 1, 2'b10, 8'h00, 1, 0, 0);
        end
        check_all("ser_final", 'h00, 8);

        // rotate sequence (recirculation only in the rotate build)
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        exp_rot1 = 'h03;
        exp_rot3 = 'hC0;
`else
        exp_rot1 = 'h02;
        exp_rot3 = 'h00;
`endif
        cyc(0, 1, 2'b11, 8'h81, 0, 0, 0);
        cyc(0, 1, 2'b01, 8'h00, 0, 0, 1);
        check_all("rot_left", exp_rot1, 1);
        cyc(0, 1, 2'b10, 8'h00, 0, 0, 1);
        cyc(0, 1, 2'b10, 8'h00, 0, 0, 1);
        check_all("rot_right2", exp_rot3, 3);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check_all($sformatf("rand%0d", i), m_q, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
